// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Controller that time-shares one 4-bit adder slice over NIBBLES cycles to
// produce a W = 4*NIBBLES bit sum, least-significant nibble first. A ripple
// carry register links successive slice cycles.
//
// Optional build macro: ADD_SUB_EN adds a 'sub' input; sub=1 computes a-b as
// a + ~b + 1, and cout becomes the not-borrow flag.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request an operation; accepted only while ready=1
//   a, b   in   W-bit operands, sampled on the accepting edge
//   sub    in   (ADD_SUB_EN only) subtract select, sampled with a/b
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle completion pulse
//   sum    out  W-bit result of the last completed operation
//   cout   out  carry out of the MSB nibble of the last completed operation
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_sh, b_sh, part, part_nx;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           last;
  logic [4:0]     slice;

  assign last  = (cnt == CW'(NIBBLES - 1));
  assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};

  // Each slice result enters at the MSB end so that after NIBBLES shifts the
  // least-significant nibble has reached bit 0.
  generate
    if (NIBBLES == 1) begin : g_one
      assign part_nx = slice[3:0];
    end else begin : g_many
      assign part_nx = {slice[3:0], part[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            cnt  <= '0;
`ifdef ADD_SUB_EN
            // Subtraction as a + ~b + 1: invert B once here, seed carry with 1.
            b_sh  <= sub ? ~b : b;
            carry <= sub;
`else
            b_sh  <= b;
            carry <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          carry <= slice[4];
          cnt   <= cnt + CW'(1);
          part  <= part_nx;
          if (last) begin
            sum  <= part_nx;
            cout <= slice[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule
